// File: rtl/uart_cmd_decoder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_cmd_decoder_pkg : command/response codes and state encodings
// Revision 1.0
// ----------------------------------------------------------------------------
package uart_cmd_decoder_pkg;

  localparam logic [7:0] c_cmd_write    = 8'h01;
  localparam logic [7:0] c_cmd_read     = 8'h02;
  localparam logic [7:0] c_cmd_refresh  = 8'h03;
  localparam logic [7:0] c_ack          = 8'h06;
  localparam logic [7:0] c_nak          = 8'h15;
  localparam logic [7:0] c_sync_default = 8'hA5;

  typedef enum logic [3:0] {
    S_SYNC    = 4'd0,
    S_CMD     = 4'd1,
    S_ADDR_H  = 4'd2,
    S_ADDR_L  = 4'd3,
    S_LEN     = 4'd4,
    S_DATA    = 4'd5,
    S_CSUM    = 4'd6,
    S_RESP    = 4'd7,
    S_RD_REQ  = 4'd8,
    S_RD_WAIT = 4'd9,
    S_TX_DATA = 4'd10,
    S_TX_CSUM = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_START   = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_t;

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == c_cmd_write) || (cmd == c_cmd_read) || (cmd == c_cmd_refresh);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_sender.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_byte_sender : one-byte send/done wrapper around the UART tx handshake
// Revision 1.0
// ----------------------------------------------------------------------------
module uart_byte_sender
  import uart_cmd_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       done
);

  tx_state_t r_state;
  tx_state_t w_state_next;
  logic      w_start_next;
  logic      w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= TX_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      r_state  <= w_state_next;
      tx_start <= w_start_next;
      if (w_load) tx_data <= data;
    end
  end

  // tx_data is only reloaded from idle, so it stays stable until tx_busy falls
  always_comb begin
    w_state_next = r_state;
    w_start_next = 1'b0;
    w_load       = 1'b0;
    done         = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (send) begin
          w_load       = 1'b1;
          w_state_next = TX_START;
        end
      end
      TX_START: begin
        if (!tx_busy) begin
          w_start_next = 1'b1;
          w_state_next = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: begin
        if (tx_busy) w_state_next = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        if (!tx_busy) begin
          done         = 1'b1;
          w_state_next = TX_IDLE;
        end
      end
      default: w_state_next = TX_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_cmd_decoder : parses framed host commands into framebuffer writes/reads/refresh
// Revision 1.0
// ----------------------------------------------------------------------------
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = c_sync_default
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_error,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              refresh_start,
  output logic              busy
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_cmd;
  logic [7:0]       r_addr_hi;
  logic [7:0]       r_len;
  logic [7:0]       r_cnt;
  logic [7:0]       r_csum;
  logic [7:0]       r_rd_xor;
  logic [7:0]       r_send_data;
  logic             r_send;
  logic             r_resp_ok;
  logic [TMR_W-1:0] r_timer;
  logic             w_snd_done;
  logic             w_rx_phase;
  logic             w_timeout;
  logic             w_abort;
  logic             w_csum_ok;

  assign w_rx_phase = (r_state == S_CMD) || (r_state == S_ADDR_H) || (r_state == S_ADDR_L) ||
                      (r_state == S_LEN) || (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_timeout  = (r_timer == TMR_W'(TIMEOUT_CYCLES));
  assign w_abort    = w_rx_phase && (rx_error || (!rx_valid && w_timeout));
  assign w_csum_ok  = (r_csum == rx_data) && is_known_cmd(r_cmd);
  assign busy       = (r_state != S_SYNC);
  assign mem_re     = (r_state == S_RD_REQ);

  uart_byte_sender u_sender (
    .clk      (clk),
    .rst_n    (rst_n),
    .send     (r_send),
    .data     (r_send_data),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .done     (w_snd_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_SYNC;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = S_SYNC;
    end else begin
      case (r_state)
        S_SYNC:    if (rx_valid && rx_data == SYNC_BYTE) w_state_next = S_CMD;
        S_CMD:     if (rx_valid) w_state_next = S_ADDR_H;
        S_ADDR_H:  if (rx_valid) w_state_next = S_ADDR_L;
        S_ADDR_L:  if (rx_valid) w_state_next = S_LEN;
        S_LEN:     if (rx_valid) w_state_next = (r_cmd == c_cmd_write && rx_data != 8'd0) ? S_DATA : S_CSUM;
        S_DATA:    if (rx_valid && r_cnt == 8'd1) w_state_next = S_CSUM;
        S_CSUM:    if (rx_valid) w_state_next = S_RESP;
        S_RESP: begin
          if (w_snd_done) begin
            if (!(r_resp_ok && r_cmd == c_cmd_read)) w_state_next = S_SYNC;
            else if (r_len == 8'd0)                  w_state_next = S_TX_CSUM;
            else                                     w_state_next = S_RD_REQ;
          end
        end
        S_RD_REQ:  w_state_next = S_RD_WAIT;
        S_RD_WAIT: w_state_next = S_TX_DATA;
        S_TX_DATA: if (w_snd_done) w_state_next = (r_cnt == 8'd0) ? S_TX_CSUM : S_RD_REQ;
        S_TX_CSUM: if (w_snd_done) w_state_next = S_SYNC;
        default:   w_state_next = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd         <= 8'h00;
      r_addr_hi     <= 8'h00;
      r_len         <= 8'h00;
      r_cnt         <= 8'h00;
      r_csum        <= 8'h00;
      r_rd_xor      <= 8'h00;
      r_send_data   <= 8'h00;
      r_send        <= 1'b0;
      r_resp_ok     <= 1'b0;
      r_timer       <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 8'h00;
      refresh_start <= 1'b0;
    end else begin
      mem_we        <= 1'b0;
      refresh_start <= 1'b0;
      r_send        <= 1'b0;
      r_timer       <= (w_rx_phase && !rx_valid) ? r_timer + TMR_W'(1) : '0;
      // write address advances after each committed byte, wrapping naturally
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      if (!w_abort) begin
        case (r_state)
          S_CMD: if (rx_valid) begin
            r_cmd  <= rx_data;
            r_csum <= rx_data;
          end
          S_ADDR_H: if (rx_valid) begin
            r_addr_hi <= rx_data;
            r_csum    <= r_csum ^ rx_data;
          end
          S_ADDR_L: if (rx_valid) begin
            mem_addr <= ADDR_W'({r_addr_hi, rx_data});
            r_csum   <= r_csum ^ rx_data;
          end
          S_LEN: if (rx_valid) begin
            r_len  <= rx_data;
            r_cnt  <= rx_data;
            r_csum <= r_csum ^ rx_data;
          end
          S_DATA: if (rx_valid) begin
            mem_we    <= 1'b1;
            mem_wdata <= rx_data;
            r_cnt     <= r_cnt - 8'd1;
            r_csum    <= r_csum ^ rx_data;
          end
          S_CSUM: if (rx_valid) begin
            r_resp_ok     <= w_csum_ok;
            r_send        <= 1'b1;
            r_send_data   <= w_csum_ok ? c_ack : c_nak;
            refresh_start <= w_csum_ok && (r_cmd == c_cmd_refresh);
            r_cnt         <= r_len;
            r_rd_xor      <= 8'h00;
          end
          S_RESP: if (w_state_next == S_TX_CSUM) begin
            r_send      <= 1'b1;
            r_send_data <= r_rd_xor;
          end
          S_RD_WAIT: begin
            r_send      <= 1'b1;
            r_send_data <= mem_rdata;
            r_rd_xor    <= r_rd_xor ^ mem_rdata;
            r_cnt       <= r_cnt - 8'd1;
          end
          S_TX_DATA: if (w_snd_done) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            if (w_state_next == S_TX_CSUM) begin
              r_send      <= 1'b1;
              r_send_data <= r_rd_xor;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_cmd_decoder : directed frames, scoreboarded TX bytes and memory traffic
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_uart_cmd_decoder;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned TIMEOUT = 300;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_error = 1'b0;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic              refresh_start;
  logic              busy;

  uart_cmd_decoder #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_error      (rx_error),
    .tx_busy       (tx_busy),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .refresh_start (refresh_start),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for a fixed number of cycles after transmit
  int unsigned uart_cnt = 0;
  always @(posedge clk) begin
    if (tx_start)          uart_cnt <= 12;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end
  assign tx_busy = (uart_cnt != 0);

  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Observed-event logs, written only here
  logic [7:0]        tx_log [0:63];
  logic [ADDR_W+7:0] wr_log [0:63];
  logic [ADDR_W-1:0] rd_log [0:63];
  int tx_n = 0, wr_n = 0, rd_n = 0, ref_n = 0;
  always @(negedge clk) begin
    if (tx_start && tx_n < 64) begin tx_log[tx_n] <= tx_data; tx_n <= tx_n + 1; end
    if (mem_we && wr_n < 64)   begin wr_log[wr_n] <= {mem_addr, mem_wdata}; wr_n <= wr_n + 1; end
    if (mem_re && rd_n < 64)   begin rd_log[rd_n] <= mem_addr; rd_n <= rd_n + 1; end
    if (refresh_start)         ref_n <= ref_n + 1;
  end

  logic [7:0]        exp_tx [$];
  logic [ADDR_W+7:0] exp_wr [$];
  logic [ADDR_W-1:0] exp_rd [$];
  int exp_ref = 0;
  int tx_rd = 0, wr_rd = 0, rd_rd = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input logic [127:0] bytes);
    for (int i = n - 1; i >= 0; i--) send_byte(bytes[i*8 +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_tx_count"}, tx_n - tx_rd, exp_tx.size());
    while (exp_tx.size() != 0 && tx_rd < tx_n) begin
      chk({tag, "_tx"}, {24'd0, tx_log[tx_rd]}, {24'd0, exp_tx.pop_front()}); tx_rd++;
    end
    chk({tag, "_wr_count"}, wr_n - wr_rd, exp_wr.size());
    while (exp_wr.size() != 0 && wr_rd < wr_n) begin
      chk({tag, "_wr"}, {8'd0, wr_log[wr_rd]}, {8'd0, exp_wr.pop_front()}); wr_rd++;
    end
    chk({tag, "_rd_count"}, rd_n - rd_rd, exp_rd.size());
    while (exp_rd.size() != 0 && rd_rd < rd_n) begin
      chk({tag, "_rd"}, {16'd0, rd_log[rd_rd]}, {16'd0, exp_rd.pop_front()}); rd_rd++;
    end
    chk({tag, "_refresh"}, ref_n, exp_ref);
    tx_rd = tx_n; wr_rd = wr_n; rd_rd = rd_n;
    exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_refresh", {31'd0, refresh_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // WRITE preceded by noise bytes that must be discarded
    exp_wr.push_back({16'h0010, 8'hAB}); exp_wr.push_back({16'h0011, 8'hCD});
    exp_tx.push_back(8'h06);
    send_frame(10, 80'h00_33_A5_01_00_10_02_AB_CD_75);
    wait_idle("write"); drain("write");

    exp_tx.push_back(8'h06); exp_tx.push_back(8'hAB); exp_tx.push_back(8'hCD); exp_tx.push_back(8'h66);
    exp_rd.push_back(16'h0010); exp_rd.push_back(16'h0011);
    send_frame(6, 48'hA5_02_00_10_02_10);
    wait_idle("read"); drain("read");

    exp_tx.push_back(8'h15);
    send_frame(6, 48'hA5_03_00_00_00_00);
    wait_idle("refresh_bad"); drain("refresh_bad");

    exp_tx.push_back(8'h06); exp_ref = exp_ref + 1;
    send_frame(6, 48'hA5_03_00_00_00_03);
    wait_idle("refresh_good"); drain("refresh_good");

    exp_tx.push_back(8'h15);
    send_frame(6, 48'hA5_07_00_00_00_07);
    wait_idle("unknown"); drain("unknown");

    // Inter-byte timeout after the command byte
    send_frame(2, 16'hA5_01);
    repeat (TIMEOUT - 20) @(negedge clk);
    chk("timeout_still_busy", {31'd0, busy}, 32'd1);
    repeat (40) @(negedge clk);
    chk("timeout_aborted", {31'd0, busy}, 32'd0);
    drain("timeout");
    exp_wr.push_back({16'h0040, 8'h5A}); exp_tx.push_back(8'h06);
    send_frame(7, 56'hA5_01_00_40_01_5A_1A);
    wait_idle("after_timeout"); drain("after_timeout");

    exp_wr.push_back({16'hFFFF, 8'h11}); exp_wr.push_back({16'h0000, 8'h22});
    exp_tx.push_back(8'h06);
    send_frame(8, 64'hA5_01_FF_FF_02_11_22_30);
    wait_idle("wrap_write"); drain("wrap_write");

    exp_tx.push_back(8'h06); exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
    exp_rd.push_back(16'hFFFF); exp_rd.push_back(16'h0000);
    send_frame(6, 48'hA5_02_FF_FF_02_00);
    wait_idle("wrap_read"); drain("wrap_read");

    exp_tx.push_back(8'h06); exp_tx.push_back(8'h00);
    send_frame(6, 48'hA5_02_00_00_00_02);
    wait_idle("read_len0"); drain("read_len0");

    // rx_error mid-data: committed byte stays written, no response
    exp_wr.push_back({16'h0020, 8'h55});
    send_frame(6, 48'hA5_01_00_20_02_55);
    @(negedge clk); rx_error = 1'b1;
    @(negedge clk); rx_error = 1'b0;
    wait_idle("rx_error"); drain("rx_error");

    // Asynchronous reset while the ACK is being launched
    exp_tx.push_back(8'h06);
    send_frame(6, 48'hA5_02_00_10_02_10);
    n = 0;
    while (!tx_start && n < 200) begin @(negedge clk); n++; end
    chk("tx_start_seen", {31'd0, tx_start}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    drain("async_rst");

    exp_tx.push_back(8'h06); exp_ref = exp_ref + 1;
    send_frame(6, 48'hA5_03_00_00_00_03);
    wait_idle("post_reset"); drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Host-side command engine on the user end of the UART byte interface. It consumes received bytes, parses framed host commands, and turns them into framebuffer memory writes and reads or a panel refresh trigger. It sends ACK/NAK and read-back data through the UART transmit handshake. It sits between the UART and the framebuffer/refresh logic of the e-ink controller.

## Interface
Parameters:
- ADDR_W, 16, framebuffer byte-address width
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between bytes inside a frame
- SYNC_BYTE, 8'hA5, frame start marker

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  master clock
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle pulse, byte received (UART `received`)
- rx_data  in  8  received byte, valid with rx_valid
- rx_error  in  1  one-cycle pulse, UART framing error
- tx_busy  in  1  UART `is_transmitting`
- tx_start  out  1  one-cycle transmit request (UART `transmit`)
- tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls
- mem_we  out  1  framebuffer write strobe
- mem_re  out  1  framebuffer read strobe
- mem_addr  out  ADDR_W  framebuffer byte address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_re
- refresh_start  out  1  one-cycle pulse, start panel refresh
- busy  out  1  high in every state except S_SYNC

## Operation
- Frame format: SYNC, CMD, ADDR_H, ADDR_L, LEN, LEN data bytes (WRITE only), CSUM. CSUM is the XOR of CMD through the last data byte.
- Commands:
  - 0x01 WRITE: writes LEN bytes starting at ADDR.
  - 0x02 READ: returns LEN bytes starting at ADDR.
  - 0x03 REFRESH: ADDR and LEN are ignored.
  - Any other CMD is unknown.
- States: S_SYNC, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CSUM, S_RESP, S_RD_REQ, S_RD_WAIT, S_TX_DATA, S_TX_CSUM.
- S_SYNC discards every byte except SYNC_BYTE.
- S_LEN goes to S_DATA if CMD==0x01 and LEN!=0, otherwise to S_CSUM.
- WRITE data bytes are committed as they arrive; mem_addr post-increments. A bad CSUM does not roll back writes already made.
- S_CSUM response:
  - Mismatch or unknown CMD: respond NAK 0x15.
  - Match: respond ACK 0x06. REFRESH also pulses refresh_start. READ goes on to the read phase after the ACK.
- Read phase, per byte: mem_re, then latch mem_rdata, then transmit.
- After LEN read bytes, transmit the XOR of the read bytes. READ with LEN=0 sends ACK and then 0x00.
- Address arithmetic is modulo 2^ADDR_W; 0xFFFF+1 wraps to 0x0000.
- Abort rules:
  - rx_error in any receive state (S_CMD..S_CSUM): return to S_SYNC with no response.
  - Inter-byte counter reaches TIMEOUT_CYCLES in S_CMD..S_CSUM: return to S_SYNC with no response.
  - The counter clears on every rx_valid.
- rx_valid and rx_error are ignored in S_RESP and the read/transmit states. Bytes arriving then are dropped.

## Timing
- Reset values: state S_SYNC; all outputs 0, including tx_data, mem_addr and mem_wdata.
- mem_we is registered. It asserts the cycle after rx_valid of a data byte, for exactly 1 cycle.
- refresh_start asserts the cycle after rx_valid of a matching CSUM.
- Transmit handshake, for each byte:
  1. Wait until tx_busy is low.
  2. Drive tx_start for 1 cycle.
  3. Wait for tx_busy to go high, then wait for it to go low.
  4. Move to the next byte.
- tx_start is never held high, so the UART recover state exits immediately.
- Read latency: mem_re in S_RD_REQ; mem_rdata is sampled in S_RD_WAIT on the following cycle.
- Reset mid-frame or mid-transmit takes effect immediately. tx_start and mem_we drop asynchronously.

## Structure
- Shared package holds the command codes (0x01/0x02/0x03), ACK/NAK codes (0x06/0x15), SYNC default, and the state encoding.
- One natural sub-module, uart_byte_sender. It owns the tx_busy handshake (idle, start, wait_hi, wait_lo) and gives a send/done interface to the parser.

## Test plan
- WRITE: A5 01 00 10 02 AB CD 75.
  - Required: writes 0x0010=AB and 0x0011=CD, then TX 0x06.
- READ of the same addresses: A5 02 00 10 02 10.
  - Required: TX 06 AB CD 66. mem_re occurs twice, at 0x0010 and 0x0011.
- REFRESH with bad checksum: A5 03 00 00 00 00.
  - Required: TX 0x15, no refresh_start.
- REFRESH with good checksum: A5 03 00 00 00 03.
  - Required: one refresh_start pulse, TX 0x06.
- Timeout: A5 01 followed by TIMEOUT_CYCLES of silence.
  - Required: returns to S_SYNC with no TX. A valid frame sent next is accepted.
- Wrap: A5 01 FF FF 02 11 22 30.
  - Required: writes 0xFFFF=11 and 0x0000=22, then ACK.
- rx_error injected during S_DATA.
  - Required: abort with no TX.
